// File: rtl/matrix_pkg.sv
package matrix_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int unsigned N_ELEM   = 9;
  localparam logic [3:0]  LAST_IDX = 4'd8;

endpackage

// File: rtl/matrix_result_serializer.sv
module matrix_result_serializer
  import matrix_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done,
  input  logic [DW-1:0] c11,
  input  logic [DW-1:0] c12,
  input  logic [DW-1:0] c13,
  input  logic [DW-1:0] c21,
  input  logic [DW-1:0] c22,
  input  logic [DW-1:0] c23,
  input  logic [DW-1:0] c31,
  input  logic [DW-1:0] c32,
  input  logic [DW-1:0] c33,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [3:0]    out_index,
  output logic          out_last,
  output logic          overrun,
  output logic          busy
);

  state_t state, state_next;

  logic [N_ELEM-1:0][DW-1:0] frame_in;
  logic [N_ELEM-1:0][DW-1:0] act;
  logic [N_ELEM-1:0][DW-1:0] pend;
  logic                      pend_full;
  logic [3:0]                idx;
  logic                      hs;
  logic                      last_hs;

  // Element 0 (c11) sits in the least significant slot.
  assign frame_in = {c33, c32, c31, c23, c22, c21, c13, c12, c11};

  assign out_valid = (state == SEND);
  assign out_index = idx;
  assign out_data  = out_valid ? act[idx] : '0;
  assign out_last  = out_valid && (idx == LAST_IDX);
  assign busy      = (state == SEND) || pend_full;

  assign hs      = out_valid && out_ready;
  assign last_hs = hs && (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (done) state_next = SEND;
      SEND: if (last_hs && !pend_full && !done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act       <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      idx       <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (done) begin
            act <= frame_in;
            idx <= '0;
          end
        end
        SEND: begin
          if (last_hs) begin
            idx <= '0;
            // The slot freed by the pending->active move takes a coincident done.
            if (pend_full) begin
              act <= pend;
              if (done) pend <= frame_in;
              else      pend_full <= 1'b0;
            end else if (done) begin
              act <= frame_in;
            end
          end else begin
            if (hs) idx <= idx + 4'd1;
            if (done) begin
              if (pend_full) begin
                overrun <= 1'b1;
              end else begin
                pend      <= frame_in;
                pend_full <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/matrix_result_serializer.md
MATRIX_RESULT_SERIALIZER -- requirements
Module: matrix_result_serializer

Interface
REQ-001 SHALL have parameter DW, default 16, meaning width of each result element and of out_data.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port done  input  1  single-cycle pulse from the 3x3 multiplier marking c11..c33 valid in that cycle.
REQ-005 SHALL have ports c11,c12,c13,c21,c22,c23,c31,c32,c33  input  DW each  multiplier result matrix, row-major names.
REQ-006 SHALL have port out_valid  output  1  out_data holds a valid element.
REQ-007 SHALL have port out_ready  input  1  downstream accepts the element when asserted together with out_valid.
REQ-008 SHALL have port out_data  output  DW  current result element.
REQ-009 SHALL have port out_index  output  4  element index 0..8 of out_data, row-major (0=c11, 8=c33).
REQ-010 SHALL have port out_last  output  1  high with out_valid when out_index==8.
REQ-011 SHALL have port overrun  output  1  sticky flag: a done pulse was dropped.
REQ-012 SHALL have port busy  output  1  high whenever active or pending buffer holds a frame.

Function
REQ-013 SHALL hold two 9-element frame buffers: active (being sent) and pending (queued).
REQ-014 SHALL use FSM states IDLE (no frame) and SEND (active frame streaming).
REQ-015 In IDLE, done SHALL capture c11..c33 into active, clear index to 0, enter SEND; out_valid high the next cycle (latency 1).
REQ-016 In SEND, a handshake (out_valid && out_ready) SHALL advance index by 1; no handshake SHALL hold out_data/out_index/out_last stable.
REQ-017 Handshake at index 8 with pending empty SHALL return to IDLE, out_valid low next cycle.
REQ-018 Handshake at index 8 with pending full SHALL move pending to active, clear pending, reset index to 0, stay in SEND with out_valid continuously high (no bubble).
REQ-019 done in SEND with pending empty SHALL capture results into pending.
REQ-020 done in SEND with pending full SHALL be dropped (neither buffer changes) and set overrun.
REQ-021 done coincident with the index-8 handshake and pending full SHALL capture into pending after the move (the freed slot is used); overrun NOT set.
REQ-022 done coincident with the index-8 handshake and pending empty SHALL capture directly into active, index 0, stay in SEND.
REQ-023 overrun SHALL remain set until rst; done outside these rules SHALL never alter a frame mid-stream.
REQ-024 out_data SHALL be passed unmodified, no width change or arithmetic.
REQ-025 busy SHALL equal (state==SEND) || pending full.

Reset
REQ-026 rst SHALL immediately force IDLE, out_valid=0, out_last=0, out_index=0, out_data=0, overrun=0, busy=0, pending empty.
REQ-027 rst mid-frame SHALL discard both buffers; first done after rst release starts a fresh frame at index 0.

Structure
REQ-028 State encodings (IDLE, SEND), element count 9 and last index 8 SHALL live in the shared matrix package, reused by the multiplier top.
REQ-029 Design SHALL be a single module; no sub-module required.

Verification
REQ-030 Identity frame: c11=c22=c33=1, others 0, done pulse, out_ready=1 -> 9 beats in consecutive cycles, data 1,0,0,0,1,0,0,0,1, out_last only on beat 9, then IDLE.
REQ-031 Backpressure: c=1..9, out_ready toggling 1/0 each cycle -> data 1..9 in order, each held stable while out_ready=0, 9 handshakes total.
REQ-032 Queueing: done (c all 0x00AA) then done (c all 0x0055) at beat 3 -> 9 beats 0x00AA immediately followed by 9 beats 0x0055, no gap, overrun=0.
REQ-033 Overrun: out_ready=0, three done pulses -> first two frames delivered intact after out_ready=1, third dropped, overrun=1, busy=1 until last beat.
REQ-034 Coincident: done on the same cycle as index-8 handshake with pending full -> pending streams next, new frame follows, overrun=0.
REQ-035 Reset mid-frame: rst at beat 4 -> out_valid=0 asynchronously, overrun=0; next done with c=0xFFFF streams 9 beats 0xFFFF from index 0.
